// File: rtl/pl_order_book_ndepth_if.sv
// rtl/pl_order_book_ndepth_if.sv - depth update handshake between the parser stage and the order book
interface pl_order_book_ndepth_if #(
  parameter int PRICE_WIDTH = 32,
  parameter int QTY_WIDTH   = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_side;
  logic [PRICE_WIDTH-1:0] in_price;
  logic [QTY_WIDTH-1:0]   in_qty;
  logic                   upd_done;

  // Parser side: offers updates, observes acceptance and completion
  modport master (
    output in_valid, in_side, in_price, in_qty,
    input  in_ready, upd_done
  );

  // Book side: accepts updates, reports completion
  modport slave (
    input  in_valid, in_side, in_price, in_qty,
    output in_ready, upd_done
  );
endinterface

// File: rtl/pl_order_book_ndepth.sv
// rtl/pl_order_book_ndepth.sv - sorted DEPTH-level two-sided order book for one symbol
module pl_order_book_ndepth #(
  parameter int DEPTH       = 8,
  parameter int PRICE_WIDTH = 32,
  parameter int QTY_WIDTH   = 32,
  parameter int CNT_WIDTH   = 32,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  pl_order_book_ndepth_if.slave  upd_if,
  input  logic                   clear_i,
  output logic                   best_bid_valid_o,
  output logic [PRICE_WIDTH-1:0] best_bid_price_o,
  output logic [QTY_WIDTH-1:0]   best_bid_qty_o,
  output logic                   best_ask_valid_o,
  output logic [PRICE_WIDTH-1:0] best_ask_price_o,
  output logic [QTY_WIDTH-1:0]   best_ask_qty_o,
  output logic [LVL_W-1:0]       bid_count_o,
  output logic [LVL_W-1:0]       ask_count_o,
  output logic                   crossed_o,
  output logic [CNT_WIDTH-1:0]   ovf_count_o,
  output logic [CNT_WIDTH-1:0]   miss_del_count_o,
  input  logic                   rd_side_i,
  input  logic [LVL_W-1:0]       rd_level_i,
  output logic                   rd_valid_o,
  output logic [PRICE_WIDTH-1:0] rd_price_o,
  output logic [QTY_WIDTH-1:0]   rd_qty_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMP   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Side index 0 holds bids (descending), index 1 holds asks (ascending).
  // Slots at or beyond the count are always zero, which keeps the
  // empty-side outputs at zero without extra muxing.
  logic [PRICE_WIDTH-1:0] lvl_price_q [2][DEPTH];
  logic [PRICE_WIDTH-1:0] lvl_price_d [2][DEPTH];
  logic [QTY_WIDTH-1:0]   lvl_qty_q   [2][DEPTH];
  logic [QTY_WIDTH-1:0]   lvl_qty_d   [2][DEPTH];
  logic [LVL_W-1:0]       cnt_q       [2];
  logic [LVL_W-1:0]       cnt_d       [2];

  state_t                 state_q;
  logic                   in_ready_q;
  logic                   upd_done_q;
  logic                   side_q;
  logic [PRICE_WIDTH-1:0] cap_price_q;
  logic [QTY_WIDTH-1:0]   cap_qty_q;

  logic                   hit_d, hit_q;
  logic [LVL_W-1:0]       idx_d, idx_q;
  logic [LVL_W-1:0]       ins_d, ins_q;

  logic                   ovf_inc;
  logic                   miss_inc;
  logic [CNT_WIDTH-1:0]   ovf_q;
  logic [CNT_WIDTH-1:0]   miss_q;

  logic                   best_bid_valid_q, best_ask_valid_q, crossed_q;
  logic [PRICE_WIDTH-1:0] best_bid_price_q, best_ask_price_q;
  logic [QTY_WIDTH-1:0]   best_bid_qty_q, best_ask_qty_q;

  logic                   rd_valid_d, rd_valid_q;
  logic [PRICE_WIDTH-1:0] rd_price_d, rd_price_q;
  logic [QTY_WIDTH-1:0]   rd_qty_d, rd_qty_q;

  logic                   accept;
  assign accept = upd_if.in_valid && in_ready_q;

  // Update sequencer: capture in IDLE, compare in CMP, commit in WRITE; clear aborts anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      upd_done_q  <= 1'b0;
      side_q      <= 1'b0;
      cap_price_q <= '0;
      cap_qty_q   <= '0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      ins_q       <= '0;
    end else begin
      upd_done_q <= 1'b0;
      if (clear_i) begin
        state_q    <= S_IDLE;
        in_ready_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              side_q      <= upd_if.in_side;
              cap_price_q <= upd_if.in_price;
              cap_qty_q   <= upd_if.in_qty;
              state_q     <= S_CMP;
              in_ready_q  <= 1'b0;
            end else begin
              in_ready_q  <= 1'b1;
            end
          end
          S_CMP: begin
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            ins_q   <= ins_d;
            state_q <= S_WRITE;
          end
          S_WRITE: begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            upd_done_q <= 1'b1;
          end
          default: begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Parallel compare of the captured price against the occupied levels of its side
  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    ins_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (LVL_W'(i) < cnt_q[side_q]) begin
        if (lvl_price_q[side_q][i] == cap_price_q && !hit_d) begin
          hit_d = 1'b1;
          idx_d = LVL_W'(i);
        end
        // A level stays ahead of the new price unless the new price is strictly better
        if (side_q ? !(cap_price_q < lvl_price_q[side_q][i])
                   : !(cap_price_q > lvl_price_q[side_q][i])) begin
          ins_d = ins_d + LVL_W'(1);
        end
      end
    end
  end

  // Next book contents: flush on clear, otherwise apply the captured update during WRITE
  always_comb begin
    lvl_price_d = lvl_price_q;
    lvl_qty_d   = lvl_qty_q;
    cnt_d       = cnt_q;
    ovf_inc     = 1'b0;
    miss_inc    = 1'b0;
    if (clear_i) begin
      for (int s = 0; s < 2; s++) begin
        cnt_d[s] = '0;
        for (int i = 0; i < DEPTH; i++) begin
          lvl_price_d[s][i] = '0;
          lvl_qty_d[s][i]   = '0;
        end
      end
    end else if (state_q == S_WRITE) begin
      if (cap_qty_q != '0) begin
        if (hit_q) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (LVL_W'(i) == idx_q) lvl_qty_d[side_q][i] = cap_qty_q;
          end
        end else if (ins_q < LVL_W'(DEPTH)) begin
          // Shift the tail down one slot; on a full side the last level falls off
          for (int i = 1; i < DEPTH; i++) begin
            if (LVL_W'(i) > ins_q) begin
              lvl_price_d[side_q][i] = lvl_price_q[side_q][i-1];
              lvl_qty_d[side_q][i]   = lvl_qty_q[side_q][i-1];
            end
          end
          for (int i = 0; i < DEPTH; i++) begin
            if (LVL_W'(i) == ins_q) begin
              lvl_price_d[side_q][i] = cap_price_q;
              lvl_qty_d[side_q][i]   = cap_qty_q;
            end
          end
          if (cnt_q[side_q] == LVL_W'(DEPTH)) ovf_inc = 1'b1;
          else cnt_d[side_q] = cnt_q[side_q] + LVL_W'(1);
        end else begin
          ovf_inc = 1'b1;
        end
      end else if (hit_q) begin
        // Close the gap left by the deleted level and zero the vacated last slot
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (LVL_W'(i) >= idx_q) begin
            lvl_price_d[side_q][i] = lvl_price_q[side_q][i+1];
            lvl_qty_d[side_q][i]   = lvl_qty_q[side_q][i+1];
          end
        end
        lvl_price_d[side_q][DEPTH-1] = '0;
        lvl_qty_d[side_q][DEPTH-1]   = '0;
        cnt_d[side_q] = cnt_q[side_q] - LVL_W'(1);
      end else begin
        miss_inc = 1'b1;
      end
    end
  end

  // Book storage plus top-of-book summary taken from the next-state book so both land together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          lvl_price_q[s][i] <= '0;
          lvl_qty_q[s][i]   <= '0;
        end
      end
      best_bid_valid_q <= 1'b0;
      best_bid_price_q <= '0;
      best_bid_qty_q   <= '0;
      best_ask_valid_q <= 1'b0;
      best_ask_price_q <= '0;
      best_ask_qty_q   <= '0;
      crossed_q        <= 1'b0;
    end else begin
      lvl_price_q      <= lvl_price_d;
      lvl_qty_q        <= lvl_qty_d;
      cnt_q            <= cnt_d;
      best_bid_valid_q <= (cnt_d[0] != '0);
      best_bid_price_q <= lvl_price_d[0][0];
      best_bid_qty_q   <= lvl_qty_d[0][0];
      best_ask_valid_q <= (cnt_d[1] != '0);
      best_ask_price_q <= lvl_price_d[1][0];
      best_ask_qty_q   <= lvl_qty_d[1][0];
      crossed_q        <= (cnt_d[0] != '0) && (cnt_d[1] != '0) &&
                          (lvl_price_d[0][0] >= lvl_price_d[1][0]);
    end
  end

  // Saturating statistics; clear leaves them untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= '0;
      miss_q <= '0;
    end else begin
      if (ovf_inc && ovf_q != '1)   ovf_q  <= ovf_q + CNT_WIDTH'(1);
      if (miss_inc && miss_q != '1) miss_q <= miss_q + CNT_WIDTH'(1);
    end
  end

  // Random-access level select for debug readout
  always_comb begin
    rd_valid_d = (rd_level_i < cnt_q[rd_side_i]);
    rd_price_d = '0;
    rd_qty_d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_valid_d && LVL_W'(i) == rd_level_i) begin
        rd_price_d = lvl_price_q[rd_side_i][i];
        rd_qty_d   = lvl_qty_q[rd_side_i][i];
      end
    end
  end

  // Readout register: one cycle latency, independent of the update sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_price_q <= '0;
      rd_qty_q   <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_price_q <= rd_price_d;
      rd_qty_q   <= rd_qty_d;
    end
  end

  assign upd_if.in_ready  = in_ready_q;
  assign upd_if.upd_done  = upd_done_q;
  assign best_bid_valid_o = best_bid_valid_q;
  assign best_bid_price_o = best_bid_price_q;
  assign best_bid_qty_o   = best_bid_qty_q;
  assign best_ask_valid_o = best_ask_valid_q;
  assign best_ask_price_o = best_ask_price_q;
  assign best_ask_qty_o   = best_ask_qty_q;
  assign bid_count_o      = cnt_q[0];
  assign ask_count_o      = cnt_q[1];
  assign crossed_o        = crossed_q;
  assign ovf_count_o      = ovf_q;
  assign miss_del_count_o = miss_q;
  assign rd_valid_o       = rd_valid_q;
  assign rd_price_o       = rd_price_q;
  assign rd_qty_o         = rd_qty_q;

endmodule

// File: tb/tb_pl_order_book_ndepth.sv
// tb/tb_pl_order_book_ndepth.sv - randomized bench with a queue-based book model
module tb_pl_order_book_ndepth;
  localparam int DEPTH     = 4;
  localparam int LVL_W     = $clog2(DEPTH + 1);
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             rd_side = 1'b0;
  logic [LVL_W-1:0] rd_level = '0;

  logic             best_bid_valid, best_ask_valid, crossed, rd_valid;
  logic [31:0]      best_bid_price, best_bid_qty, best_ask_price, best_ask_qty;
  logic [31:0]      rd_price, rd_qty;
  logic [LVL_W-1:0] bid_count, ask_count;
  logic [CNT_WIDTH-1:0] ovf_count, miss_del_count;

  pl_order_book_ndepth_if #(.PRICE_WIDTH(32), .QTY_WIDTH(32)) upd_if ();

  pl_order_book_ndepth #(.DEPTH(DEPTH), .PRICE_WIDTH(32), .QTY_WIDTH(32), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst), .upd_if(upd_if), .clear_i(clear),
    .best_bid_valid_o(best_bid_valid), .best_bid_price_o(best_bid_price), .best_bid_qty_o(best_bid_qty),
    .best_ask_valid_o(best_ask_valid), .best_ask_price_o(best_ask_price), .best_ask_qty_o(best_ask_qty),
    .bid_count_o(bid_count), .ask_count_o(ask_count), .crossed_o(crossed),
    .ovf_count_o(ovf_count), .miss_del_count_o(miss_del_count),
    .rd_side_i(rd_side), .rd_level_i(rd_level),
    .rd_valid_o(rd_valid), .rd_price_o(rd_price), .rd_qty_o(rd_qty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rd_manual = 1'b0;
  bit exp_in_ready = 1'b0;
  bit exp_upd_done = 1'b0;
  bit exp_rd_valid = 1'b0;
  int unsigned exp_rd_price = 0;
  int unsigned exp_rd_qty = 0;

  // Model book: bids best-first (highest), asks best-first (lowest)
  int unsigned bp[$], bq[$], ap[$], aq[$];
  int m_ovf = 0;
  int m_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  function automatic int cnt(input bit s);
    return s ? ap.size() : bp.size();
  endfunction

  function automatic int unsigned lvl(input bit s, input int i, input bit want_qty);
    if (s) begin
      if (i < ap.size()) return want_qty ? aq[i] : ap[i];
    end else begin
      if (i < bp.size()) return want_qty ? bq[i] : bp[i];
    end
    return 0;
  endfunction

  function automatic bit model_crossed();
    return (bp.size() > 0) && (ap.size() > 0) && (lvl(0, 0, 0) >= lvl(1, 0, 0));
  endfunction

  task automatic model_clear();
    bp.delete(); bq.delete(); ap.delete(); aq.delete();
  endtask

  task automatic model_apply(input bit s, input int unsigned p, input int unsigned q);
    int unsigned lp[$];
    int unsigned lq[$];
    int idx;
    int pos;
    if (s) begin lp = ap; lq = aq; end else begin lp = bp; lq = bq; end
    idx = -1;
    foreach (lp[i]) if (lp[i] == p) idx = i;
    if (q == 0) begin
      if (idx < 0) m_miss++;
      else begin lp.delete(idx); lq.delete(idx); end
    end else if (idx >= 0) begin
      lq[idx] = q;
    end else begin
      pos = 0;
      while (pos < lp.size() && !(s ? (p < lp[pos]) : (p > lp[pos]))) pos++;
      lp.insert(pos, p);
      lq.insert(pos, q);
      if (lp.size() > DEPTH) begin
        void'(lp.pop_back());
        void'(lq.pop_back());
        m_ovf++;
      end
    end
    if (s) begin ap = lp; aq = lq; end else begin bp = lp; bq = lq; end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", upd_if.in_ready, exp_in_ready);
      check("upd_done", upd_if.upd_done, exp_upd_done);
      check("bid_valid", best_bid_valid, bp.size() > 0);
      check("bid_price", best_bid_price, lvl(0, 0, 0));
      check("bid_qty", best_bid_qty, lvl(0, 0, 1));
      check("ask_valid", best_ask_valid, ap.size() > 0);
      check("ask_price", best_ask_price, lvl(1, 0, 0));
      check("ask_qty", best_ask_qty, lvl(1, 0, 1));
      check("bid_count", bid_count, cnt(0));
      check("ask_count", ask_count, cnt(1));
      check("crossed", crossed, model_crossed());
      check("ovf_count", ovf_count, sat(m_ovf));
      check("miss_del_count", miss_del_count, sat(m_miss));
      check("rd_valid", rd_valid, exp_rd_valid);
      check("rd_price", rd_price, exp_rd_price);
      check("rd_qty", rd_qty, exp_rd_qty);
    end
  end

  // Readout expectation taken from the model as it stands at each request edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst || int'(rd_level) >= cnt(rd_side)) begin
        exp_rd_valid = 1'b0;
        exp_rd_price = 0;
        exp_rd_qty   = 0;
      end else begin
        exp_rd_valid = 1'b1;
        exp_rd_price = lvl(rd_side, int'(rd_level), 0);
        exp_rd_qty   = lvl(rd_side, int'(rd_level), 1);
      end
      #2;
      if (!rd_manual) begin
        rd_side  = 1'($urandom_range(0, 1));
        rd_level = LVL_W'($urandom_range(0, (1 << LVL_W) - 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_upd_done = 1'b0;
  endtask

  task automatic do_update(input bit s, input int unsigned p, input int unsigned q);
    upd_if.in_valid = 1'b1;
    upd_if.in_side  = s;
    upd_if.in_price = p;
    upd_if.in_qty   = q;
    tick();
    upd_if.in_valid = 1'b0;
    upd_if.in_side  = 1'($urandom_range(0, 1));
    upd_if.in_price = $urandom;
    upd_if.in_qty   = $urandom;
    exp_in_ready = 1'b0;
    tick();
    tick();
    exp_upd_done = 1'b1;
    exp_in_ready = 1'b1;
    model_apply(s, p, q);
  endtask

  task automatic clear_cycle(input bit with_valid);
    clear = 1'b1;
    if (with_valid) begin
      upd_if.in_valid = 1'b1;
      upd_if.in_side  = 1'b0;
      upd_if.in_price = 7;
      upd_if.in_qty   = 7;
    end
    tick();
    clear = 1'b0;
    upd_if.in_valid = 1'b0;
    model_clear();
    exp_in_ready = 1'b1;
  endtask

  initial begin
    upd_if.in_valid = 1'b0;
    upd_if.in_side  = 1'b0;
    upd_if.in_price = 0;
    upd_if.in_qty   = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_in_ready = 1'b1;

    // Three bids arriving out of order
    do_update(0, 100, 5);
    do_update(0, 102, 3);
    do_update(0, 101, 7);
    check("t1_model_l0", lvl(0, 0, 0), 102);
    check("t1_model_l1", lvl(0, 1, 0), 101);
    check("t1_model_l2", lvl(0, 2, 0), 100);
    check("t1_best_bid", best_bid_price, 102);
    check("t1_best_qty", best_bid_qty, 3);
    check("t1_bid_count", bid_count, 3);

    // Full ask side: better insert evicts worst, worse insert is dropped
    for (int p = 10; p <= 13; p++) do_update(1, p, 1);
    do_update(1, 9, 2);
    check("t2_best_ask", best_ask_price, 9);
    check("t2_ask_count", ask_count, 4);
    check("t2_ovf_evict", ovf_count, 1);
    check("t2_model_l3", lvl(1, 3, 0), 12);
    do_update(1, 20, 4);
    check("t2_ovf_drop", ovf_count, 2);
    check("t2_model_l3b", lvl(1, 3, 0), 12);

    // Insert then delete, and delete of an absent price
    clear_cycle(0);
    do_update(0, 50, 8);
    do_update(0, 50, 0);
    check("t3_bid_count", bid_count, 0);
    check("t3_bid_valid", best_bid_valid, 0);
    do_update(0, 77, 0);
    check("t3_miss", miss_del_count, 1);

    // Crossed book set and cleared
    do_update(0, 105, 1);
    do_update(1, 104, 1);
    check("t4_crossed_set", crossed, 1);
    do_update(1, 104, 0);
    check("t4_crossed_clr", crossed, 0);

    // Clear while the update is in its compare cycle
    upd_if.in_valid = 1'b1;
    upd_if.in_side  = 1'b0;
    upd_if.in_price = 60;
    upd_if.in_qty   = 1;
    tick();
    upd_if.in_valid = 1'b0;
    exp_in_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    exp_in_ready = 1'b1;
    check("t5_bid_count", bid_count, 0);
    check("t5_ask_count", ask_count, 0);
    check("t5_ovf_kept", ovf_count, 2);
    repeat (3) tick();
    do_update(1, 30, 3);
    clear_cycle(1);
    check("t5_ask_cleared", ask_count, 0);
    tick();

    // Random traffic over a narrow price band so matches, evictions and drops are frequent
    repeat (300) begin
      if ($urandom_range(0, 39) == 0) clear_cycle(0);
      else do_update(1'($urandom_range(0, 1)), $urandom_range(95, 110), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Readout edges on a full side, then reset in the middle of WRITE
    clear_cycle(0);
    for (int p = 1; p <= DEPTH; p++) do_update(0, p, p);
    rd_manual = 1'b1;
    rd_side   = 1'b0;
    rd_level  = LVL_W'(DEPTH - 1);
    tick();
    check("t6_rd_last_valid", rd_valid, 1);
    check("t6_rd_last_price", rd_price, 1);
    rd_level = LVL_W'(DEPTH);
    tick();
    check("t6_rd_full_oor", rd_valid, 0);
    rd_level = '0;
    upd_if.in_valid = 1'b1;
    upd_if.in_side  = 1'b0;
    upd_if.in_price = 9;
    upd_if.in_qty   = 9;
    tick();
    upd_if.in_valid = 1'b0;
    exp_in_ready = 1'b0;
    tick();
    rst = 1'b1;
    model_clear();
    m_ovf = 0;
    m_miss = 0;
    exp_rd_valid = 1'b0;
    exp_rd_price = 0;
    exp_rd_qty   = 0;
    #1;
    check("t6_rst_bid_count", bid_count, 0);
    check("t6_rst_bid_valid", best_bid_valid, 0);
    check("t6_rst_bid_price", best_bid_price, 0);
    check("t6_rst_ovf", ovf_count, 0);
    check("t6_rst_rd_valid", rd_valid, 0);
    check("t6_rst_in_ready", upd_if.in_ready, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    exp_in_ready = 1'b1;
    rd_level = LVL_W'(DEPTH);
    tick();
    check("t6_rd_depth_valid", rd_valid, 0);
    check("t6_rd_depth_price", rd_price, 0);
    rd_manual = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
